gate_event_tx: RTL and testbench
================================

GATE_EVENT_TX -- requirements
Module: gate_event_tx

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port entry_req, input, 1, one-cycle pulse: car at entry gate.
REQ-004 SHALL have port exit_req, input, 1, one-cycle pulse: car at exit gate.
REQ-005 SHALL have port exit_req_slot, input, 2, slot being vacated; qualified by exit_req.
REQ-006 SHALL have port is_full, input, 1, from parking FSM: no free slot.
REQ-007 SHALL have port spots, input, 4, from parking FSM: occupancy bitmap, bit n = slot n occupied.
REQ-008 SHALL have port entry_signal, output, 1, registered one-cycle entry event to FSM.
REQ-009 SHALL have port exit_signal, output, 1, registered one-cycle exit event to FSM.
REQ-010 SHALL have port exit_slot, output, 2, slot of issued exit; 0 when exit_signal low.
REQ-011 SHALL have port entry_pending, output, 3, count of queued entry requests.
REQ-012 SHALL have port drop, output, 1, one-cycle pulse: request lost (queue overflow).
REQ-013 SHALL have port bad_exit, output, 1, one-cycle pulse: exit for unoccupied slot discarded.

Function
REQ-014 SHALL queue entries in a saturating 3-bit counter (max 7); entry_req at 7 SHALL pulse drop next cycle, count unchanged.
REQ-015 SHALL queue exits in a 4-deep FIFO of 2-bit slots; exit_req when full SHALL pulse drop, request discarded.
REQ-016 SHALL accept entry_req and exit_req in the same cycle; both queued.
REQ-017 SHALL net counter increment and decrement in the same cycle (count unchanged).
REQ-018 SHALL run FSM states IDLE, ISSUE, SETTLE; ISSUE->SETTLE->IDLE unconditionally, one cycle each.
REQ-019 SHALL in IDLE give exit FIFO priority: if non-empty, pop head; spots[slot]=1 -> ISSUE exit; else pulse bad_exit, stay IDLE.
REQ-020 SHALL in IDLE with exit FIFO empty, entry_pending>0 and is_full=0 -> ISSUE entry, decrement count.
REQ-021 SHALL hold entries while is_full=1 without dropping; resume once is_full=0.
REQ-022 SHALL assert entry_signal or exit_signal (never both) for exactly one cycle, while state=ISSUE.
REQ-023 SHALL latency: request sampled at edge k with FSM idle and queues empty -> event output high between edges k+2 and k+3.
REQ-024 SHALL space issued events at least 3 cycles apart (SETTLE lets FSM update spots/is_full).
REQ-025 SHALL evaluate spots and is_full only in IDLE; values in other states ignored.

Reset
REQ-026 SHALL on reset=0 immediately force state IDLE, entry_pending=0, FIFO empty, all outputs 0.
REQ-027 SHALL on reset mid-ISSUE drop the in-flight pulse and discard all queued requests.
REQ-028 SHALL ignore entry_req/exit_req during reset; first acceptance at first rising edge after release.

Structure
REQ-029 SHALL place state encoding (IDLE/ISSUE/SETTLE), ENTRY_QMAX=7, EXIT_DEPTH=4, SLOT_W=2 in shared package parking_pkg.
REQ-030 SHALL implement exit queue as sub-module slot_fifo (depth/width parameters, push/pop/full/empty).

Verification
REQ-031 SHALL test: entry_req once, is_full=0 -> entry_signal one cycle, 2 edges later; entry_pending 1->0.
REQ-032 SHALL test: spots=4'b0100, exit_req slot 2 -> exit_signal=1, exit_slot=2 one cycle; slot 1 instead -> bad_exit pulse, no exit_signal.
REQ-033 SHALL test: is_full=1, 8 entry_req -> entry_pending=7, one drop pulse; is_full->0 -> 7 entry_signal pulses 3 cycles apart.
REQ-034 SHALL test: entry_req and exit_req (slot 0, spots=4'b0001) same cycle -> exit_signal issued first, entry_signal 3 cycles later.
REQ-035 SHALL test: 5 exit_req back-to-back while busy -> fifth pulses drop; 4 exits issued in order.
REQ-036 SHALL test: reset=0 during ISSUE with 3 entries pending -> outputs 0 immediately, entry_pending=0, no events after release.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and sizing for the parking gate event path.
// Pure declarations: no latency, no flow control.
package parking_pkg;

   localparam int ENTRY_QMAX  = 7;
   localparam int EXIT_DEPTH  = 4;
   localparam int SLOT_W      = 2;
   localparam int NUM_SLOTS   = 1 << SLOT_W;
   localparam int ENTRY_CNT_W = $clog2(ENTRY_QMAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2
   } gate_state_t;

   typedef logic [SLOT_W-1:0] slot_t;

   typedef struct packed {
      logic  entry;
      logic  exit;
      slot_t slot;
   } gate_req_t;

endpackage

// File: rtl/slot_fifo.sv
// Small synchronous FIFO holding queued exit slots; head is visible combinationally.
// Latency: one cycle push-to-head; a push while full is ignored unless a pop frees room in the same cycle.
module slot_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gate_event_tx.sv
// Queues entry/exit gate requests and paces them to the parking FSM as one-cycle events.
// Latency: event 2 cycles after an idle request, >=3 cycles apart; no backpressure, overflow pulses drop.
module gate_event_tx
   import parking_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   entry_req,
   input  logic                   exit_req,
   input  logic [SLOT_W-1:0]      exit_req_slot,
   input  logic                   is_full,
   input  logic [NUM_SLOTS-1:0]   spots,
   output logic                   entry_signal,
   output logic                   exit_signal,
   output logic [SLOT_W-1:0]      exit_slot,
   output logic [ENTRY_CNT_W-1:0] entry_pending,
   output logic                   drop,
   output logic                   bad_exit
);

   localparam logic [ENTRY_CNT_W-1:0] QMAX = ENTRY_CNT_W'(ENTRY_QMAX);

   gate_state_t state;
   gate_req_t   req_q;
   slot_t       fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        take_exit;
   logic        take_entry;
   logic        entry_inc;
   logic        entry_ovf;
   logic        exit_ovf;

   // Requests are registered once before queueing, giving the fixed 2-cycle idle latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q <= '0;
      end else begin
         req_q <= '{entry: entry_req, exit: exit_req, slot: exit_req_slot};
      end
   end

   assign take_exit  = (state == IDLE) && !fifo_empty;
   assign take_entry = (state == IDLE) && fifo_empty && (entry_pending != '0) && !is_full;

   // A request arriving at capacity is kept if a slot is freed in the same cycle.
   assign entry_ovf = req_q.entry && (entry_pending == QMAX) && !take_entry;
   assign entry_inc = req_q.entry && !entry_ovf;
   assign exit_ovf  = req_q.exit && fifo_full && !take_exit;
   assign fifo_push = req_q.exit && !exit_ovf;

   slot_fifo #(
      .DEPTH (EXIT_DEPTH),
      .WIDTH (SLOT_W)
   ) u_exit_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .push     (fifo_push),
      .push_dat (req_q.slot),
      .pop      (take_exit),
      .head_dat (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         entry_pending <= '0;
      end else if (entry_inc && !take_entry) begin
         entry_pending <= entry_pending + 1'b1;
      end else if (!entry_inc && take_entry) begin
         entry_pending <= entry_pending - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop <= 1'b0;
      end else begin
         drop <= entry_ovf || exit_ovf;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         entry_signal <= 1'b0;
         exit_signal  <= 1'b0;
         exit_slot    <= '0;
         bad_exit     <= 1'b0;
      end else begin
         entry_signal <= 1'b0;
         exit_signal  <= 1'b0;
         exit_slot    <= '0;
         bad_exit     <= 1'b0;
         case (state)
            IDLE: begin
               if (take_exit) begin
                  // An exit for an empty slot is consumed without spending an ISSUE/SETTLE window.
                  if (spots[fifo_head]) begin
                     state       <= ISSUE;
                     exit_signal <= 1'b1;
                     exit_slot   <= fifo_head;
                  end else begin
                     bad_exit <= 1'b1;
                  end
               end else if (take_entry) begin
                  state        <= ISSUE;
                  entry_signal <= 1'b1;
               end
            end
            ISSUE:   state <= SETTLE;
            SETTLE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_event_tx.sv
// Randomized and directed bench for gate_event_tx with a queue-based reference model and scoreboard.
module tb_gate_event_tx;

   localparam int EV_ENTRY = 0;
   localparam int EV_EXIT  = 1;
   localparam int EV_BAD   = 2;
   localparam int EV_DROP  = 3;

   typedef struct {
      int kind;
      int slot;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       entry_req;
   logic       exit_req;
   logic [1:0] exit_req_slot;
   logic       is_full;
   logic [3:0] spots;
   logic       entry_signal;
   logic       exit_signal;
   logic [1:0] exit_slot;
   logic [2:0] entry_pending;
   logic       drop;
   logic       bad_exit;

   int   errors = 0;
   int   checks = 0;
   int   edge_n = 0;

   ev_t  exp_q[$];
   int   m_fifo[$];
   int   m_cnt;
   int   m_busy;
   bit   p_entry;
   bit   p_exit;
   int   p_slot;

   gate_event_tx dut (
      .clk           (clk),
      .reset         (reset),
      .entry_req     (entry_req),
      .exit_req      (exit_req),
      .exit_req_slot (exit_req_slot),
      .is_full       (is_full),
      .spots         (spots),
      .entry_signal  (entry_signal),
      .exit_signal   (exit_signal),
      .exit_slot     (exit_slot),
      .entry_pending (entry_pending),
      .drop          (drop),
      .bad_exit      (bad_exit)
   );

   always #5 clk = ~clk;

   function automatic string kname(input int k);
      case (k)
         EV_ENTRY: return "entry";
         EV_EXIT:  return "exit";
         EV_BAD:   return "bad_exit";
         default:  return "drop";
      endcase
   endfunction

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic check_ev(input int kind, input int slot);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event: got %s slot %0d at edge %0d, expected none", kname(kind), slot, edge_n);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != kind || e.slot != slot || e.cyc != edge_n) begin
         errors++;
         $display("FAIL event: got %s slot %0d at edge %0d, expected %s slot %0d at edge %0d",
                  kname(kind), slot, edge_n, kname(e.kind), e.slot, e.cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int slot);
      ev_t e;
      e.kind = kind;
      e.slot = slot;
      e.cyc  = edge_n;
      exp_q.push_back(e);
   endtask

   // Reference model: an integer entry count, a slot queue, and a busy countdown of two
   // cycles after each issued event; requests take effect one edge after they are sampled.
   initial begin
      int  h;
      bit  dropped;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_cnt   = 0;
            m_busy  = 0;
            p_entry = 0;
            p_exit  = 0;
            p_slot  = 0;
            m_fifo.delete();
            exp_q.delete();
         end else begin
            edge_n++;
            if (m_busy == 0) begin
               if (m_fifo.size() != 0) begin
                  h = m_fifo.pop_front();
                  if (spots[h]) begin
                     expect_ev(EV_EXIT, h);
                     m_busy = 2;
                  end else begin
                     expect_ev(EV_BAD, 0);
                  end
               end else if (m_cnt > 0 && !is_full) begin
                  expect_ev(EV_ENTRY, 0);
                  m_cnt--;
                  m_busy = 2;
               end
            end else begin
               m_busy--;
            end
            dropped = 0;
            if (p_entry) begin
               if (m_cnt < 7) m_cnt++;
               else dropped = 1;
            end
            if (p_exit) begin
               if (m_fifo.size() < 4) m_fifo.push_back(p_slot);
               else dropped = 1;
            end
            if (dropped) expect_ev(EV_DROP, 0);
            p_entry = entry_req;
            p_exit  = exit_req;
            p_slot  = int'(exit_req_slot);
         end
      end
   end

   // Monitor: samples DUT outputs on the falling edge and retires scoreboard entries.
   initial begin
      int last_ev;
      last_ev = -100;
      forever begin
         @(negedge clk);
         if (!reset) begin
            last_ev = -100;
         end else begin
            check_val("single_event", int'(entry_signal && exit_signal), 0);
            if (!exit_signal) check_val("exit_slot_quiet", int'(exit_slot), 0);
            check_val("entry_pending", int'(entry_pending), m_cnt);
            if (bad_exit)     check_ev(EV_BAD, 0);
            if (entry_signal) check_ev(EV_ENTRY, 0);
            if (exit_signal)  check_ev(EV_EXIT, int'(exit_slot));
            if (drop)         check_ev(EV_DROP, 0);
            if (entry_signal || exit_signal) begin
               check_val("event_spacing_ge3", int'(edge_n - last_ev >= 3), 1);
               last_ev = edge_n;
            end
            while (exp_q.size() != 0 && exp_q[0].cyc <= edge_n) begin
               checks++;
               errors++;
               $display("FAIL missed_event: got nothing at edge %0d, expected %s slot %0d",
                        edge_n, kname(exp_q[0].kind), exp_q[0].slot);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic pulse(input bit en, input bit ex, input int slot);
      entry_req     = en;
      exit_req      = ex;
      exit_req_slot = 2'(slot);
      tick();
      entry_req = 1'b0;
      exit_req  = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_entry_signal"},  int'(entry_signal), 0);
      check_val({tag, "_exit_signal"},   int'(exit_signal), 0);
      check_val({tag, "_exit_slot"},     int'(exit_slot), 0);
      check_val({tag, "_entry_pending"}, int'(entry_pending), 0);
      check_val({tag, "_drop"},          int'(drop), 0);
      check_val({tag, "_bad_exit"},      int'(bad_exit), 0);
   endtask

   initial begin
      bit found;
      reset         = 1'b1;
      entry_req     = 1'b0;
      exit_req      = 1'b0;
      exit_req_slot = 2'd0;
      is_full       = 1'b0;
      spots         = 4'b0000;
      #2 reset = 1'b0;
      entry_req = 1'b1;
      exit_req  = 1'b1;
      #10;
      check_quiet("reset");
      entry_req = 1'b0;
      exit_req  = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;

      // Single entry with a free lot.
      pulse(1, 0, 0);
      idle(8);

      // Exit for an occupied slot, then for an empty one.
      spots = 4'b0100;
      pulse(0, 1, 2);
      idle(8);
      pulse(0, 1, 1);
      idle(8);

      // Entries pile up while full, eighth overflows, then drain when space appears.
      is_full = 1'b1;
      repeat (8) pulse(1, 0, 0);
      idle(4);
      is_full = 1'b0;
      idle(30);

      // Simultaneous entry and exit: exit wins.
      spots = 4'b0001;
      pulse(1, 1, 0);
      idle(12);

      // Exit burst behind a busy FSM overflows the exit queue.
      spots = 4'b1111;
      pulse(1, 0, 0);
      for (int s = 0; s < 6; s++) pulse(0, 1, s % 4);
      idle(30);

      // Reset while an entry is in ISSUE with three more queued.
      is_full = 1'b1;
      repeat (4) pulse(1, 0, 0);
      idle(3);
      is_full = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (entry_signal) found = 1;
      end
      check_val("issue_seen_before_reset", int'(found), 1);
      check_val("pending_at_issue", int'(entry_pending), 3);
      reset = 1'b0;
      #1;
      check_quiet("mid_issue_reset");
      tick();
      tick();
      reset = 1'b1;
      idle(20);

      // Randomized traffic.
      for (int c = 0; c < 2000; c++) begin
         entry_req     = ($urandom_range(0, 3) == 0);
         exit_req      = ($urandom_range(0, 4) == 0);
         exit_req_slot = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) spots = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) is_full = ~is_full;
         tick();
      end
      is_full = 1'b0;
      idle(80);
      check_val("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
